// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared defaults and the occupancy-count width helper for q_pipe
package q_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/q_cell.sv
// rtl/q_cell.sv - one pipeline stage: data register, full flag, load/vacate update
module q_cell
  import q_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             src_valid,
  input  logic             vacate,
  input  logic [WIDTH-1:0] src_data,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic load;

  // A full stage may reload on the same edge it hands its word onward.
  assign load = src_valid && (!full || vacate);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= src_data;
    end else if (vacate) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/q_pipe.sv
// rtl/q_pipe.sv - elastic valid/ready pipeline of DEPTH q_cell stages
module q_pipe
  import q_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      pi,
  input  logic [WIDTH-1:0]          din,
  output logic                      po,
  output logic                      so,
  output logic [WIDTH-1:0]          dout,
  input  logic                      si,
  output logic [DEPTH-1:0]          f,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] vac;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic             in_ready;
  logic             rdy;

  // Vacate chain ripples from si back toward the input stage.
  always_comb begin
    vac = '0;
    rdy = si;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      vac[i] = f[i] && rdy;
      rdy    = !f[i] || vac[i];
    end
    in_ready = rdy;
  end

  assign po = in_ready && !rst && !flush;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign src_valid[g] = pi && po;
        q_cell #(.WIDTH(WIDTH)) u_cell (
          .clk       (clk),
          .rst       (rst),
          .flush     (flush),
          .src_valid (src_valid[g]),
          .vacate    (vac[g]),
          .src_data  (din),
          .full      (f[g]),
          .data      (stage_data[g])
        );
      end else begin : g_body
        assign src_valid[g] = f[g-1] && vac[g-1];
        q_cell #(.WIDTH(WIDTH)) u_cell (
          .clk       (clk),
          .rst       (rst),
          .flush     (flush),
          .src_valid (src_valid[g]),
          .vacate    (vac[g]),
          .src_data  (stage_data[g-1]),
          .full      (f[g]),
          .data      (stage_data[g])
        );
      end
    end
  endgenerate

  assign so   = f[DEPTH-1];
  assign dout = stage_data[DEPTH-1];

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(f[i]);
    end
  end

endmodule

// File: tb/tb_q_pipe.sv
// tb/tb_q_pipe.sv - directed self-checking bench for q_pipe (WIDTH=8, DEPTH=4)
module tb_q_pipe;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       pi;
  logic [7:0] din;
  logic       po;
  logic       so;
  logic [7:0] dout;
  logic       si;
  logic [3:0] f;
  logic [2:0] count;

  int nvec;
  int nerr;

  q_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .pi    (pi),
    .din   (din),
    .po    (po),
    .so    (so),
    .dout  (dout),
    .si    (si),
    .f     (f),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1; flush = 1'b0; pi = 1'b0; si = 1'b0; din = 8'h00;

    // reset for two edges, po low throughout
    #1;
    chk("po_in_reset", po, 0);
    step();
    step();
    chk("po_in_reset2", po, 0);
    rst = 1'b0;
    #1;
    chk("rst_f", f, 4'b0000);
    chk("rst_count", count, 0);
    chk("rst_so", so, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_po", po, 1);

    // single word latency
    pi = 1'b1; si = 1'b1; din = 8'hA5;
    step();
    pi = 1'b0;
    chk("lat_f0", f, 4'b0001);
    step();
    chk("lat_so1", so, 0);
    step();
    chk("lat_so2", so, 0);
    step();
    chk("lat_so3", so, 1);
    chk("lat_dout3", dout, 8'hA5);
    step();
    chk("lat_so4", so, 0);
    chk("lat_hold", dout, 8'hA5);

    // backpressure fill: only 0x01..0x04 enter
    si = 1'b0; pi = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din = 8'(k);
      #1;
      chk("fill_po", po, 1);
      step();
    end
    din = 8'h05;
    #1;
    chk("full_po", po, 0);
    step();
    chk("full_f", f, 4'b1111);
    chk("full_count", count, 4);
    chk("full_dout", dout, 8'h01);
    step();
    chk("full_hold_dout", dout, 8'h01);
    chk("full_hold_count", count, 4);
    si = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) din = 8'h06;
      if (k == 3) pi = 1'b0;
      #1;
      chk("drain_so", so, 1);
      chk("drain_dout", dout, 8'(k));
      step();
    end
    chk("drain_empty_so", so, 0);
    chk("drain_empty_count", count, 0);

    // fill with 0x10..0x13 then stream 10 words at full rate
    si = 1'b0; pi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 8'h10 + 8'(k);
      step();
    end
    chk("stream_full", f, 4'b1111);
    si = 1'b1;
    for (int j = 0; j < 10; j++) begin
      din = 8'h14 + 8'(j);
      #1;
      chk("stream_po", po, 1);
      chk("stream_dout", dout, 8'h10 + 8'(j));
      step();
      chk("stream_count", count, 4);
    end
    pi = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("stream_tail", dout, 8'h1A + 8'(j));
      step();
    end
    chk("stream_done_so", so, 0);

    // flush with three words held; 0x77 must not be taken
    si = 1'b0; pi = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 8'h31 + 8'(k);
      step();
    end
    chk("pre_flush_f", f, 4'b0111);
    flush = 1'b1; din = 8'h77;
    #1;
    chk("flush_po", po, 0);
    step();
    chk("flush_f", f, 4'b0000);
    chk("flush_count", count, 0);
    chk("flush_so", so, 0);
    flush = 1'b0; si = 1'b1; din = 8'h44;
    step();
    pi = 1'b0;
    step();
    step();
    step();
    chk("post_flush_so", so, 1);
    chk("post_flush_dout", dout, 8'h44);
    step();
    chk("post_flush_empty", so, 0);

    // reset overrides flush on a full pipe
    si = 1'b0; pi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 8'h51 + 8'(k);
      step();
    end
    chk("pre_rst_f", f, 4'b1111);
    rst = 1'b1; flush = 1'b1; din = 8'h99;
    #1;
    chk("rst_flush_po", po, 0);
    step();
    chk("rst_flush_f", f, 4'b0000);
    chk("rst_flush_dout", dout, 8'h00);
    chk("rst_flush_so", so, 0);
    rst = 1'b0; flush = 1'b0; pi = 1'b0; si = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("no_stale_so", so, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
